// File: rtl/bus_fabric_pkg.sv
// Shared definitions for the CPU-to-slave bus fabric: FSM state type,
// default memory map and the read data returned on an error response.
package bus_fabric_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } fab_state_t;

   // Slave 0 in the least significant word
   localparam logic [95:0] DEFAULT_SLAVE_BASE = {32'h00020000, 32'h00010000, 32'h00000000};
   localparam logic [95:0] DEFAULT_SLAVE_MASK = {32'hFFFFFF00, 32'hFFFFC000, 32'hFFFF0000};
   localparam logic [31:0] DEFAULT_ERR_RDATA  = 32'hDEADBEEF;

   function automatic logic addr_match(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] mask);
      return (addr & mask) == base;
   endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Access watchdog: counts cycles while run is high and flags the cycle in
// which the TIMEOUT_CYCLES-th run cycle occurs. TIMEOUT_CYCLES = 0 disables it.
module bus_watchdog #(
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic run,
   output logic expired
);

   if (TIMEOUT_CYCLES == 0) begin : g_off
      logic unused_inputs;
      assign unused_inputs = &{clk, rst_n, clear, run};
      assign expired = 1'b0;
   end else begin : g_on
      localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
      logic [CW-1:0] cnt;

      // expired is asserted during the last allowed cycle so that a ready
      // arriving in that same cycle still wins
      assign expired = run && (cnt == CW'(TIMEOUT_CYCLES - 1));

      // Count run cycles, cleared outside the access phase
      always_ff @(posedge clk) begin
         if (!rst_n || clear)
            cnt <= '0;
         else if (run && !expired)
            cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/bus_fabric.sv
// Single-master bus fabric: decodes a CPU memory request to one of
// NUM_SLAVES slaves, waits for its ready (bounded by a watchdog) and returns
// a one-cycle response. Optional error capture: define
// BUS_FABRIC_ERR_CAPTURE_EN to record the last faulting address and a
// saturating error count.
module bus_fabric
   import bus_fabric_pkg::*;
#(
   parameter int unsigned                  NUM_SLAVES     = 3,
   parameter logic [32*NUM_SLAVES-1:0]     SLAVE_BASE     = DEFAULT_SLAVE_BASE,
   parameter logic [32*NUM_SLAVES-1:0]     SLAVE_MASK     = DEFAULT_SLAVE_MASK,
   parameter int unsigned                  TIMEOUT_CYCLES = 256,
   parameter logic [31:0]                  ERR_RDATA      = DEFAULT_ERR_RDATA
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     mem_valid,
   input  logic                     mem_instr,
   input  logic [31:0]              mem_addr,
   input  logic [31:0]              mem_wdata,
   input  logic [3:0]               mem_wstrb,
   output logic                     mem_ready,
   output logic [31:0]              mem_rdata,
   output logic                     bus_err,
   output logic [NUM_SLAVES-1:0]    s_valid,
   input  logic [NUM_SLAVES-1:0]    s_ready,
   output logic [31:0]              s_addr,
   output logic [31:0]              s_wdata,
   output logic [3:0]               s_wstrb,
   input  logic [32*NUM_SLAVES-1:0] s_rdata,
   output logic [31:0]              err_addr,
   output logic [7:0]               err_count
);

   localparam int unsigned SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

   fab_state_t    state;
   logic [SW-1:0] sel_q;
   logic [SW-1:0] hit_idx;
   logic          hit;
   logic          ready_sel;
   logic          wd_expired;

   // Instruction fetches decode exactly like data accesses
   logic unused_instr;
   assign unused_instr = mem_instr;

   // Address decode; scanning upwards and stopping at the first hit gives
   // the lowest index priority on overlapping windows
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
         if (!hit && addr_match(mem_addr, SLAVE_BASE[32*i +: 32], SLAVE_MASK[32*i +: 32])) begin
            hit     = 1'b1;
            hit_idx = SW'(i);
         end
      end
   end

   assign ready_sel = s_ready[sel_q];

   bus_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (state != ACCESS),
      .run     (state == ACCESS),
      .expired (wd_expired)
   );

   // Request/response FSM with registered slave-side and CPU-side outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         sel_q     <= '0;
         s_valid   <= '0;
         s_addr    <= '0;
         s_wdata   <= '0;
         s_wstrb   <= '0;
         mem_ready <= 1'b0;
         mem_rdata <= '0;
         bus_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               mem_ready <= 1'b0;
               bus_err   <= 1'b0;
               if (mem_valid) begin
                  s_addr  <= mem_addr;
                  s_wdata <= mem_wdata;
                  s_wstrb <= mem_wstrb;
                  if (hit) begin
                     sel_q   <= hit_idx;
                     s_valid <= NUM_SLAVES'(1) << hit_idx;
                     state   <= ACCESS;
                  end else begin
                     mem_ready <= 1'b1;
                     bus_err   <= 1'b1;
                     mem_rdata <= ERR_RDATA;
                     state     <= RESP;
                  end
               end
            end
            ACCESS: begin
               if (!mem_valid) begin
                  s_valid <= '0;
                  state   <= IDLE;
               end else if (ready_sel) begin
                  s_valid   <= '0;
                  mem_ready <= 1'b1;
                  bus_err   <= 1'b0;
                  mem_rdata <= s_rdata[32*sel_q +: 32];
                  state     <= RESP;
               end else if (wd_expired) begin
                  s_valid   <= '0;
                  mem_ready <= 1'b1;
                  bus_err   <= 1'b1;
                  mem_rdata <= ERR_RDATA;
                  state     <= RESP;
               end
            end
            RESP: begin
               mem_ready <= 1'b0;
               bus_err   <= 1'b0;
               state     <= IDLE;
            end
            default: begin
               s_valid   <= '0;
               mem_ready <= 1'b0;
               bus_err   <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

`ifdef BUS_FABRIC_ERR_CAPTURE_EN
   logic        err_fire;
   logic [31:0] fault_addr;

   // Error detected on the same edge that moves the FSM into an error RESP,
   // so the captured values are visible together with mem_ready
   always_comb begin
      err_fire   = mem_valid &&
                   (((state == IDLE) && !hit) ||
                    ((state == ACCESS) && !ready_sel && wd_expired));
      fault_addr = (state == IDLE) ? mem_addr : s_addr;
   end

   // Last faulting address and saturating error count
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_addr  <= '0;
         err_count <= '0;
      end else if (err_fire) begin
         err_addr <= fault_addr;
         if (err_count != 8'hFF)
            err_count <= err_count + 8'd1;
      end
   end
`else
   assign err_addr  = '0;
   assign err_count = '0;
`endif

endmodule

// File: tb/tb_bus_fabric.sv
// Directed self-checking bench for bus_fabric with a response scoreboard.
// A second instance with a short watchdog exercises the timeout path.
module tb_bus_fabric;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } resp_t;

   localparam logic [31:0] ERR_RD = 32'hDEADBEEF;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         mem_valid, t_valid, mem_instr;
   logic [31:0]  mem_addr, mem_wdata;
   logic [3:0]   mem_wstrb;
   logic [2:0]   s_ready, t_ready;
   logic [31:0]  sdata [3];
   logic [95:0]  s_rdata;

   logic         mem_ready, bus_err, t_mem_ready, t_bus_err;
   logic [31:0]  mem_rdata, t_mem_rdata;
   logic [2:0]   s_valid, t_s_valid;
   logic [31:0]  s_addr, s_wdata, t_s_addr, t_s_wdata;
   logic [3:0]   s_wstrb, t_s_wstrb;
   logic [31:0]  err_addr, t_err_addr;
   logic [7:0]   err_count, t_err_count;

   resp_t        sb_q[$];
   int           checks = 0;
   int           errors = 0;
   logic [31:0]  m_err_addr = '0;
   logic [7:0]   m_err_cnt = '0;

   assign s_rdata = {sdata[2], sdata[1], sdata[0]};

   always #5 clk = ~clk;

   bus_fabric dut (
      .clk (clk), .rst_n (rst_n),
      .mem_valid (mem_valid), .mem_instr (mem_instr), .mem_addr (mem_addr),
      .mem_wdata (mem_wdata), .mem_wstrb (mem_wstrb),
      .mem_ready (mem_ready), .mem_rdata (mem_rdata), .bus_err (bus_err),
      .s_valid (s_valid), .s_ready (s_ready), .s_addr (s_addr),
      .s_wdata (s_wdata), .s_wstrb (s_wstrb), .s_rdata (s_rdata),
      .err_addr (err_addr), .err_count (err_count)
   );

   bus_fabric #(.TIMEOUT_CYCLES (4)) dut_t (
      .clk (clk), .rst_n (rst_n),
      .mem_valid (t_valid), .mem_instr (mem_instr), .mem_addr (mem_addr),
      .mem_wdata (mem_wdata), .mem_wstrb (mem_wstrb),
      .mem_ready (t_mem_ready), .mem_rdata (t_mem_rdata), .bus_err (t_bus_err),
      .s_valid (t_s_valid), .s_ready (t_ready), .s_addr (t_s_addr),
      .s_wdata (t_s_wdata), .s_wstrb (t_s_wstrb), .s_rdata (s_rdata),
      .err_addr (t_err_addr), .err_count (t_err_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_err_capture(input string tag, input logic [31:0] ea, input logic [7:0] ec);
`ifdef BUS_FABRIC_ERR_CAPTURE_EN
      chk({tag, "/err_addr"}, ea, m_err_addr);
      chk({tag, "/err_count"}, 32'(ec), 32'(m_err_cnt));
`else
      chk({tag, "/err_addr"}, ea, 32'h0);
      chk({tag, "/err_count"}, 32'(ec), 32'h0);
`endif
   endtask

   // One transaction on the main instance; slv < 0 means unmapped.
   // The selected slave answers in its (waits+1)-th s_valid cycle; noise bits
   // are driven on s_ready of the other slaves throughout.
   task automatic do_txn(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input int slv, input int waits,
                         input logic [2:0] noise);
      resp_t       e, got;
      logic [2:0]  oh;
      int          sv_cnt, exp_lat;
      bit          done;
      sv_cnt = 0;
      done   = 0;
      oh      = (slv >= 0) ? (3'b001 << slv) : 3'b000;
      exp_lat = (slv >= 0) ? 3 + waits : 2;
      e.err = (slv < 0);
      if (slv < 0) e.rdata = ERR_RD;
      else         e.rdata = sdata[slv];
      sb_q.push_back(e);
      mem_addr  = addr;
      mem_wdata = wdata;
      mem_wstrb = wstrb;
      mem_instr = addr[2];
      mem_valid = 1'b1;
      s_ready   = noise & ~oh;
      for (int c = 1; c <= 40 && !done; c++) begin
         tick();
         if (mem_ready) begin
            done = 1;
            if (sb_q.size() == 0) begin
               chk({tag, "/sb_nonempty"}, 32'h0, 32'h1);
               got = e;
            end else begin
               got = sb_q.pop_front();
            end
            chk({tag, "/rdata"}, mem_rdata, got.rdata);
            chk({tag, "/bus_err"}, 32'(bus_err), 32'(got.err));
            chk({tag, "/latency"}, 32'(c + 1), 32'(exp_lat));
            chk({tag, "/sv_cycles"}, 32'(sv_cnt), (slv >= 0) ? 32'(waits + 1) : 32'h0);
            chk({tag, "/sv_at_ready"}, 32'(s_valid), 32'h0);
            if (got.err) begin
               m_err_addr = addr;
               if (m_err_cnt != 8'hFF) m_err_cnt = m_err_cnt + 8'd1;
            end
            check_err_capture(tag, err_addr, err_count);
            mem_valid = 1'b0;
            s_ready   = '0;
            tick();
            chk({tag, "/ready_pulse"}, 32'(mem_ready), 32'h0);
            chk({tag, "/rdata_hold"}, mem_rdata, got.rdata);
         end else begin
            chk({tag, "/s_valid"}, 32'(s_valid),
                (slv >= 0 && c <= waits + 1) ? 32'(oh) : 32'h0);
            if (slv >= 0 && s_valid == oh) begin
               sv_cnt++;
               chk({tag, "/s_addr"}, s_addr, addr);
               chk({tag, "/s_wdata"}, s_wdata, wdata);
               chk({tag, "/s_wstrb"}, 32'(s_wstrb), 32'(wstrb));
            end
            s_ready = noise & ~oh;
            if (slv >= 0 && sv_cnt == waits + 1) s_ready = s_ready | oh;
         end
      end
      if (!done) begin
         chk({tag, "/response_seen"}, 32'h0, 32'h1);
         mem_valid = 1'b0;
         s_ready   = '0;
         tick();
      end
   endtask

   // Transaction on the short-watchdog instance targeting slave 2
   task automatic do_t_txn(input string tag, input bit answer_in_4th);
      resp_t e, got;
      int    sv_cnt;
      bit    done;
      sv_cnt = 0;
      done   = 0;
      e.err   = !answer_in_4th;
      e.rdata = answer_in_4th ? sdata[2] : ERR_RD;
      sb_q.push_back(e);
      mem_addr  = 32'h00020004;
      mem_wdata = 32'h0;
      mem_wstrb = 4'b0000;
      t_valid   = 1'b1;
      t_ready   = '0;
      for (int c = 1; c <= 20 && !done; c++) begin
         tick();
         if (t_mem_ready) begin
            done = 1;
            if (sb_q.size() == 0) begin
               chk({tag, "/sb_nonempty"}, 32'h0, 32'h1);
               got = e;
            end else begin
               got = sb_q.pop_front();
            end
            chk({tag, "/rdata"}, t_mem_rdata, got.rdata);
            chk({tag, "/bus_err"}, 32'(t_bus_err), 32'(got.err));
            chk({tag, "/latency"}, 32'(c + 1), 32'd6);
            chk({tag, "/sv_cycles"}, 32'(sv_cnt), 32'd4);
            chk({tag, "/sv_low"}, 32'(t_s_valid), 32'h0);
`ifdef BUS_FABRIC_ERR_CAPTURE_EN
            chk({tag, "/err_addr"}, t_err_addr, 32'h00020004);
            chk({tag, "/err_count"}, 32'(t_err_count), 32'd1);
`else
            chk({tag, "/err_addr"}, t_err_addr, 32'h0);
            chk({tag, "/err_count"}, 32'(t_err_count), 32'h0);
`endif
            t_valid = 1'b0;
            t_ready = '0;
            tick();
            chk({tag, "/ready_pulse"}, 32'(t_mem_ready), 32'h0);
         end else begin
            chk({tag, "/s_valid"}, 32'(t_s_valid), (c <= 4) ? 32'h4 : 32'h0);
            if (t_s_valid == 3'b100) sv_cnt++;
            t_ready = (answer_in_4th && sv_cnt == 4) ? 3'b100 : 3'b000;
         end
      end
      if (!done) begin
         chk({tag, "/response_seen"}, 32'h0, 32'h1);
         t_valid = 1'b0;
         t_ready = '0;
         tick();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: observed no finish expected finish");
      $fatal(1, "simulation time limit");
   end

   initial begin
      rst_n     = 1'b0;
      mem_valid = 1'b0;
      t_valid   = 1'b0;
      mem_instr = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_wstrb = '0;
      s_ready   = '0;
      t_ready   = '0;
      sdata[0]  = 32'h12345678;
      sdata[1]  = 32'hCAFEF00D;
      sdata[2]  = 32'h0BADC0DE;

      // Reset state
      repeat (3) tick();
      chk("rst/mem_ready", 32'(mem_ready), 32'h0);
      chk("rst/bus_err", 32'(bus_err), 32'h0);
      chk("rst/mem_rdata", mem_rdata, 32'h0);
      chk("rst/s_valid", 32'(s_valid), 32'h0);
      chk("rst/s_addr", s_addr, 32'h0);
      chk("rst/s_wdata", s_wdata, 32'h0);
      chk("rst/s_wstrb", 32'(s_wstrb), 32'h0);
      chk("rst/err_addr", err_addr, 32'h0);
      chk("rst/err_count", 32'(err_count), 32'h0);
      rst_n = 1'b1;
      tick();

      // Zero-wait read of slave 0
      do_txn("rd_s0", 32'h00000004, 32'h0, 4'b0000, 0, 0, 3'b000);
      // Partial write to slave 1 with four wait cycles
      do_txn("wr_s1", 32'h00010010, 32'hA5A5A5A5, 4'b0011, 1, 4, 3'b000);
      // Unmapped read, then unmapped write
      do_txn("rd_unmapped", 32'h00030000, 32'h0, 4'b0000, -1, 0, 3'b000);
      do_txn("wr_unmapped", 32'h00020100, 32'h11112222, 4'b1111, -1, 0, 3'b000);
      // Slave 2 top of window, with spurious readies from slaves 0 and 1
      do_txn("rd_s2_noise", 32'h000200FC, 32'h0, 4'b0000, 2, 2, 3'b011);
      // Slave 1 boundary of its 16 KB window
      do_txn("rd_s1_edge", 32'h00013FFC, 32'h0, 4'b0000, 1, 1, 3'b101);

      // Ready asserted with no request pending
      s_ready = 3'b111;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("idle_ready/mem_ready", 32'(mem_ready), 32'h0);
         chk("idle_ready/s_valid", 32'(s_valid), 32'h0);
      end
      s_ready = '0;

      // Request withdrawn during ACCESS
      mem_addr  = 32'h00010020;
      mem_wstrb = 4'b0000;
      mem_valid = 1'b1;
      tick();
      tick();
      chk("abort/s_valid_before", 32'(s_valid), 32'h2);
      mem_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("abort/s_valid", 32'(s_valid), 32'h0);
         chk("abort/mem_ready", 32'(mem_ready), 32'h0);
         chk("abort/bus_err", 32'(bus_err), 32'h0);
      end
      check_err_capture("abort", err_addr, err_count);

      // Watchdog expiry, then ready arriving in the last allowed cycle
      do_t_txn("timeout", 1'b0);
      do_t_txn("ready_at_limit", 1'b1);

      // Reset during ACCESS
      mem_addr  = 32'h00010040;
      mem_valid = 1'b1;
      tick();
      tick();
      chk("rst_access/s_valid_before", 32'(s_valid), 32'h2);
      rst_n = 1'b0;
      tick();
      m_err_addr = '0;
      m_err_cnt  = '0;
      chk("rst_access/s_valid", 32'(s_valid), 32'h0);
      chk("rst_access/mem_ready", 32'(mem_ready), 32'h0);
      chk("rst_access/mem_rdata", mem_rdata, 32'h0);
      check_err_capture("rst_access", err_addr, err_count);
      rst_n     = 1'b1;
      mem_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("rst_access/no_ready", 32'(mem_ready), 32'h0);
      end
      do_txn("rd_after_rst", 32'h00000000, 32'h0, 4'b0000, 0, 0, 3'b000);

      chk("sb_drained", 32'(sb_q.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
